mux_arb_reg: RTL and testbench
==============================

Name: mux_arb_reg

Overview:
- Parametrised, registered N-channel data multiplexer.
- Each input channel has its own valid/ready handshake. A single registered valid/ready output stream carries the winning channel's word.
- Two selection modes:
  - Manual: the channel is chosen by sel, as in the combinational 4:1 mux.
  - Round-robin: fair arbitration across all requesting channels.
- Sits between ALU operand/result sources and downstream consumers that need back-pressure and a pipeline register.

Parameters:
- NCH, 4, number of input channels (>= 2).
- WIDTH, 4, data bits per channel.
- SELW, $clog2(NCH), derived width of sel and out_ch. Not to be overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- mode  input  1  0 = manual select, 1 = round-robin
- sel  input  SELW  channel index used in manual mode
- in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  NCH  per-channel request
- in_ready  output  NCH  per-channel accept, one-hot or zero
- out_data  output  WIDTH  registered selected word
- out_ch  output  SELW  registered index of the channel that supplied out_data
- out_valid  output  1  out_data/out_ch hold a word
- out_ready  input  1  downstream accept

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid = 0, out_data = 0, out_ch = 0, rr pointer ptr = 0.
  - in_ready = 0 while reset is asserted.
  - Reset mid-transfer discards the held word; no partial state survives.
- Load enable: load = !out_valid || out_ready (combinational).
- Candidate selection (combinational, evaluated every cycle):
  - mode = 0: candidate = sel when sel < NCH and in_valid[sel] = 1; otherwise none. If sel >= NCH, there is no grant.
  - mode = 1: candidate = first i with in_valid[i] = 1, scanning ptr, ptr+1, ..., NCH-1, 0, ..., ptr-1 (wrap modulo NCH). No candidate if in_valid = 0.
- Grant: in_ready[c] = load for the candidate c. All other in_ready bits are 0. in_ready never depends on out_data.
- Transfer on input c: in_valid[c] && in_ready[c]. At the next clk edge:
  - out_data <= in_data[c*WIDTH +: WIDTH], out_ch <= c, out_valid <= 1.
- If load = 1 and there is no candidate: out_valid <= 0 at the edge; out_data/out_ch hold their last values.
- If load = 0 (out_valid && !out_ready): out_data, out_ch and out_valid hold. in_ready = 0.
- Simultaneous drain and refill (out_valid && out_ready && transfer): the new word replaces the old one in the same edge. Throughput is 1 word/cycle; latency is 1 cycle from accept to out_valid.
- Pointer update:
  - On a round-robin transfer from c: ptr <= (c == NCH-1) ? 0 : c+1.
  - Manual-mode transfers leave ptr unchanged.
- Changing mode or sel affects only the next arbitration. A held output word is never altered.
- Inputs are not required to hold valid when not granted. No starvation: in round-robin mode a continuously requesting channel is granted within NCH accepted transfers.

Test Plan:
- Reset, then mode=0, sel=2, in_valid=4'b1111, in_data={4'hD,4'hC,4'hB,4'hA}, out_ready=1 -> in_ready=4'b0100; one cycle later out_data=4'hC, out_ch=2, out_valid=1; repeats every cycle.
- Manual with sel=1, in_valid=4'b1101 -> in_ready=0; out_valid falls to 0 at the next edge.
- mode=1, in_valid=4'b1111, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3; ptr ends at 0.
- Round-robin back-pressure:
  - Setup: mode=1, in_valid=4'b1010, out_ready=0 after the first word.
  - Held word: out_ch=1 holds with out_valid=1; in_ready=0 while stalled.
  - Release: when out_ready=1, the next out_ch=3, then 1.
- Simultaneous drain/refill: out_valid=1, out_ready=1, in_valid[0]=1 with data 4'h5 -> the edge replaces the word with 4'h5, out_ch=0, and out_valid stays 1 with no bubble.
- Reset mid-stall: assert rst_n=0 asynchronously while out_valid=1 -> out_valid=0, out_data=0, out_ch=0 immediately with no clk edge; after release, round-robin restarts from channel 0.

Source files
------------

// File: rtl/mux_arb_reg.sv
// Registered N-channel multiplexer with per-channel valid/ready handshakes.
// The winning channel is picked by sel (manual) or by a rotating round-robin pointer.
module mux_arb_reg #(
  parameter int NCH   = 4,
  parameter int WIDTH = 4,
  parameter int SELW  = $clog2(NCH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mode,
  input  logic [SELW-1:0]        sel,
  input  logic [NCH*WIDTH-1:0]   in_data,
  input  logic [NCH-1:0]         in_valid,
  output logic [NCH-1:0]         in_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [SELW-1:0]        out_ch,
  output logic                   out_valid,
  input  logic                   out_ready
);

  logic [WIDTH-1:0] data_p1;
  logic [SELW-1:0]  ch_p1;
  logic             vld_p1;
  logic [SELW-1:0]  ptr;

  logic             load;
  logic             cand_ok;
  logic [SELW-1:0]  cand;
  logic             take;
  logic [WIDTH-1:0] cand_data;

  assign load = !vld_p1 || out_ready;
  assign take = cand_ok && load;

  // Candidate selection: manual index or first requester at/after ptr, wrapping.
  always_comb begin
    int idx;
    cand_ok = 1'b0;
    cand    = '0;
    idx     = 0;
    if (!mode) begin
      for (int i = 0; i < NCH; i++) begin
        if (SELW'(i) == sel && in_valid[i]) begin
          cand_ok = 1'b1;
          cand    = SELW'(i);
        end
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        idx = int'(ptr) + k;
        if (idx >= NCH) idx = idx - NCH;
        if (!cand_ok && in_valid[idx]) begin
          cand_ok = 1'b1;
          cand    = SELW'(idx);
        end
      end
    end
  end

  // Grant and data steering; the grant is held low throughout reset.
  always_comb begin
    in_ready  = '0;
    cand_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (cand == SELW'(i)) begin
        in_ready[i] = rst_n && take;
        cand_data   = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output register stage (p1)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      ch_p1   <= '0;
    end else if (load) begin
      vld_p1 <= take;
      if (take) begin
        data_p1 <= cand_data;
        ch_p1   <= cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (take && mode) begin
      ptr <= (cand == SELW'(NCH-1)) ? '0 : cand + 1'b1;
    end
  end

  assign out_data  = data_p1;
  assign out_ch    = ch_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_mux_arb_reg.sv
// Directed-vector bench for mux_arb_reg with hand-computed expectations.
module tb_mux_arb_reg;

  localparam int NCH   = 4;
  localparam int WIDTH = 4;
  localparam int SELW  = 2;

  logic                 clk;
  logic                 rst_n;
  logic                 mode;
  logic [SELW-1:0]      sel;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_ch;
  logic                 out_valid;
  logic                 out_ready;

  int n_chk;
  int n_err;

  mux_arb_reg #(.NCH(NCH), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [WIDTH-1:0] rr_exp_data [NCH];
    n_chk = 0;
    n_err = 0;
    rr_exp_data[0] = 4'hA;
    rr_exp_data[1] = 4'hB;
    rr_exp_data[2] = 4'hC;
    rr_exp_data[3] = 4'hD;

    rst_n     = 1'b0;
    mode      = 1'b0;
    sel       = 2'd2;
    in_data   = 16'hDCBA;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ch", out_ch, 0);
    chk("rst_in_ready", in_ready, 4'b0000);

    #9 rst_n = 1'b1;
    #1;
    chk("man_in_ready", in_ready, 4'b0100);
    tick();
    chk("man_data_1", out_data, 4'hC);
    chk("man_ch_1", out_ch, 2);
    chk("man_valid_1", out_valid, 1);
    chk("man_in_ready_2", in_ready, 4'b0100);
    tick();
    chk("man_data_2", out_data, 4'hC);
    chk("man_valid_2", out_valid, 1);

    sel      = 2'd1;
    in_valid = 4'b1101;
    #1;
    chk("man_nogrant", in_ready, 4'b0000);
    tick();
    chk("man_valid_drop", out_valid, 0);
    chk("man_data_hold", out_data, 4'hC);

    mode     = 1'b1;
    in_valid = 4'b1111;
    #1;
    chk("rr_first_grant", in_ready, 4'b0001);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("rr_ch_%0d", i), out_ch, i % NCH);
      chk($sformatf("rr_data_%0d", i), out_data, rr_exp_data[i % NCH]);
      chk($sformatf("rr_valid_%0d", i), out_valid, 1);
    end
    chk("rr_ptr_wrapped", in_ready, 4'b0001);

    in_valid = 4'b1010;
    #1;
    chk("bp_grant_1", in_ready, 4'b0010);
    tick();
    out_ready = 1'b0;
    #1;
    chk("bp_ch_1", out_ch, 1);
    chk("bp_valid_1", out_valid, 1);
    chk("bp_stall_ready", in_ready, 4'b0000);
    tick();
    chk("bp_hold_ch", out_ch, 1);
    chk("bp_hold_data", out_data, 4'hB);
    chk("bp_hold_valid", out_valid, 1);
    out_ready = 1'b1;
    #1;
    chk("bp_release_grant", in_ready, 4'b1000);
    tick();
    chk("bp_ch_3", out_ch, 3);
    chk("bp_data_3", out_data, 4'hD);
    tick();
    chk("bp_ch_1b", out_ch, 1);

    in_valid = 4'b0001;
    in_data  = 16'hDCB5;
    #1;
    chk("dr_grant", in_ready, 4'b0001);
    tick();
    chk("dr_data", out_data, 4'h5);
    chk("dr_ch", out_ch, 0);
    chk("dr_valid", out_valid, 1);

    out_ready = 1'b0;
    in_valid  = 4'b0000;
    tick();
    chk("stall_valid", out_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_data", out_data, 0);
    chk("async_rst_ch", out_ch, 0);
    chk("async_rst_ready", in_ready, 4'b0000);
    #1 rst_n = 1'b1;
    mode      = 1'b1;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    #1;
    chk("post_rst_grant", in_ready, 4'b0001);
    tick();
    chk("post_rst_ch", out_ch, 0);
    chk("post_rst_data", out_data, 4'h5);
    tick();
    chk("post_rst_ch_next", out_ch, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
